// File: rtl/rst_seq_fsm.sv
// Reset-release sequencer: staged release of NUM_STAGE reset domains after POR,
// maskable warm-reset merge, minimum hold time, and warm-reset cause/count status.
module rst_seq_fsm #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned NUM_STAGE   = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned POR_DELAY   = 8,
    parameter int unsigned STAGE_DELAY = 8,
    parameter int unsigned MIN_HOLD    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   req_en_i,
    output logic [NUM_STAGE-1:0] stage_release_o,
    output logic                 boot_done_o,
    output logic [NUM_REQ-1:0]   rst_cause_o,
    output logic [7:0]           rst_cnt_o
);

    typedef enum logic [1:0] {
        POR_WAIT = 2'd0,
        RELEASE  = 2'd1,
        WORKING  = 2'd2,
        HOLD     = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_DELAY - 1);
    localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_STAGE-1:0] stage_d;
    logic                 boot_d;
    logic [NUM_REQ-1:0]   cause_d;
    logic [7:0]           rcnt_d;
    logic [NUM_REQ-1:0]   masked_req;
    logic                 req;
    logic                 last_stage;

    assign masked_req = req_i & req_en_i;
    assign req        = |masked_req;
    assign last_stage = stage_release_o[NUM_STAGE-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= POR_WAIT;
            cnt_q           <= '0;
            stage_release_o <= '0;
            boot_done_o     <= 1'b0;
            rst_cause_o     <= '0;
            rst_cnt_o       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            stage_release_o <= stage_d;
            boot_done_o     <= boot_d;
            rst_cause_o     <= cause_d;
            rst_cnt_o       <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            POR_WAIT: begin
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q == POR_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == STG_LAST) begin
                    cnt_d = '0;
                    if (last_stage) state_d = WORKING;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WORKING: begin
                if (req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    if (!req) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = POR_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs; a request always wins over a stage boundary.
    always_comb begin
        stage_d = stage_release_o;
        boot_d  = boot_done_o;
        cause_d = rst_cause_o;
        rcnt_d  = rst_cnt_o;
        unique case (state_q)
            POR_WAIT: begin
                if (!req && cnt_q == POR_LAST) stage_d = NUM_STAGE'(1);
            end
            RELEASE, WORKING: begin
                if (req) begin
                    stage_d = '0;
                    boot_d  = 1'b0;
                    cause_d = masked_req;
                    rcnt_d  = (rst_cnt_o == 8'hFF) ? rst_cnt_o : rst_cnt_o + 8'd1;
                end else if (state_q == RELEASE && cnt_q == STG_LAST) begin
                    if (last_stage) boot_d = 1'b1;
                    else            stage_d = NUM_STAGE'({stage_release_o, 1'b1});
                end
            end
            HOLD: begin
                cause_d = rst_cause_o | masked_req;
                if (!req && cnt_q == HOLD_LAST) stage_d = NUM_STAGE'(1);
            end
            default: begin
                stage_d = '0;
                boot_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rst_seq_fsm.sv
// Self-checking bench for rst_seq_fsm: constant vector table, directed corner
// sequences, and a randomized phase compared against a timeline-based model.
module tb_rst_seq_fsm;

    localparam int unsigned NREQ = 4;
    localparam int unsigned NSTG = 4;
    localparam int unsigned PORD = 8;
    localparam int unsigned STGD = 8;
    localparam int unsigned MINH = 4;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] req_en_i;
    logic [NSTG-1:0] stage_release_o;
    logic            boot_done_o;
    logic [NREQ-1:0] rst_cause_o;
    logic [7:0]      rst_cnt_o;

    rst_seq_fsm #(
        .NUM_REQ    (NREQ),
        .NUM_STAGE  (NSTG),
        .CNT_W      (8),
        .POR_DELAY  (PORD),
        .STAGE_DELAY(STGD),
        .MIN_HOLD   (MINH)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_i          (req_i),
        .req_en_i       (req_en_i),
        .stage_release_o(stage_release_o),
        .boot_done_o    (boot_done_o),
        .rst_cause_o    (rst_cause_o),
        .rst_cnt_o      (rst_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Timeline model: POR quiet time, time since stage 0, age of the hold.
    bit          m_por, m_run, m_hold;
    int unsigned m_quiet, m_t, m_age, m_cnt;
    logic [NREQ-1:0] m_cause;

    function automatic logic [NSTG-1:0] m_stages();
        int unsigned k;
        if (!m_run) return '0;
        k = m_t / STGD + 1;
        if (k > NSTG) k = NSTG;
        return NSTG'((1 << k) - 1);
    endfunction

    function automatic logic m_boot();
        return m_run && (m_t >= NSTG * STGD);
    endfunction

    task automatic model_reset();
        m_por = 1; m_run = 0; m_hold = 0;
        m_quiet = 0; m_t = 0; m_age = 0; m_cnt = 0; m_cause = '0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] m);
        bit r;
        r = |m;
        if (m_por) begin
            m_quiet = r ? 0 : m_quiet + 1;
            if (m_quiet == PORD) begin
                m_por = 0; m_run = 1; m_t = 0;
            end
        end else if (m_run) begin
            if (r) begin
                m_run = 0; m_hold = 1; m_age = 0; m_cause = m;
                if (m_cnt < 255) m_cnt++;
            end else if (m_t < NSTG * STGD) begin
                m_t++;
            end
        end else if (m_hold) begin
            m_cause = m_cause | m;
            if (!r && m_age >= MINH - 1) begin
                m_hold = 0; m_run = 1; m_t = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [NSTG+NREQ+8:0] got, exp;
        got = {stage_release_o, boot_done_o, rst_cause_o, rst_cnt_o};
        exp = {m_stages(), m_boot(), m_cause, 8'(m_cnt)};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got stage=%b boot=%b cause=%b cnt=%0d, expected stage=%b boot=%b cause=%b cnt=%0d",
                     tag, $time, stage_release_o, boot_done_o, rst_cause_o, rst_cnt_o,
                     m_stages(), m_boot(), m_cause, m_cnt);
        end
    endtask

    task automatic check_const(input string tag, input logic [NSTG-1:0] st, input logic bd,
                               input logic [NREQ-1:0] ca, input logic [7:0] cn);
        n_checks++;
        if (stage_release_o !== st || boot_done_o !== bd || rst_cause_o !== ca || rst_cnt_o !== cn) begin
            n_fail++;
            $display("FAIL %s t=%0t: got stage=%b boot=%b cause=%b cnt=%0d, expected stage=%b boot=%b cause=%b cnt=%0d",
                     tag, $time, stage_release_o, boot_done_o, rst_cause_o, rst_cnt_o, st, bd, ca, cn);
        end
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] e, input string tag);
        req_i    = r;
        req_en_i = e;
        @(posedge clk_i);
        #1;
        model_edge(r & e);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n_i  = 1'b0;
        req_i    = '0;
        req_en_i = '1;
        #1;
        check_const("reset_async_clear", '0, 1'b0, '0, 8'd0);
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] en;
        int unsigned     cycles;
        logic [NSTG-1:0] stage;
        logic            boot;
        logic [NREQ-1:0] cause;
        logic [7:0]      cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on release, warm reset from WORKING, masked source, req on a stage boundary
        tbl[0]  = '{4'h0, 4'hF,  7, 4'b0000, 1'b0, 4'h0, 8'd0};
        tbl[1]  = '{4'h0, 4'hF,  1, 4'b0001, 1'b0, 4'h0, 8'd0};
        tbl[2]  = '{4'h0, 4'hF,  8, 4'b0011, 1'b0, 4'h0, 8'd0};
        tbl[3]  = '{4'h0, 4'hF,  8, 4'b0111, 1'b0, 4'h0, 8'd0};
        tbl[4]  = '{4'h0, 4'hF,  8, 4'b1111, 1'b0, 4'h0, 8'd0};
        tbl[5]  = '{4'h0, 4'hF,  7, 4'b1111, 1'b0, 4'h0, 8'd0};
        tbl[6]  = '{4'h0, 4'hF,  1, 4'b1111, 1'b1, 4'h0, 8'd0};
        tbl[7]  = '{4'h1, 4'hF,  1, 4'b0000, 1'b0, 4'h1, 8'd1};
        tbl[8]  = '{4'h0, 4'hF,  3, 4'b0000, 1'b0, 4'h1, 8'd1};
        tbl[9]  = '{4'h0, 4'hF,  1, 4'b0001, 1'b0, 4'h1, 8'd1};
        tbl[10] = '{4'h0, 4'hF, 31, 4'b1111, 1'b0, 4'h1, 8'd1};
        tbl[11] = '{4'h0, 4'hF,  1, 4'b1111, 1'b1, 4'h1, 8'd1};
        tbl[12] = '{4'h1, 4'hE,  5, 4'b1111, 1'b1, 4'h1, 8'd1};
        tbl[13] = '{4'h2, 4'hE,  1, 4'b0000, 1'b0, 4'h2, 8'd2};
        tbl[14] = '{4'h0, 4'hE,  3, 4'b0000, 1'b0, 4'h2, 8'd2};
        tbl[15] = '{4'h0, 4'hE,  1, 4'b0001, 1'b0, 4'h2, 8'd2};
        tbl[16] = '{4'h0, 4'hE, 15, 4'b0011, 1'b0, 4'h2, 8'd2};
        tbl[17] = '{4'h4, 4'hE,  1, 4'b0000, 1'b0, 4'h4, 8'd3};
        tbl[18] = '{4'h0, 4'hE,  3, 4'b0000, 1'b0, 4'h4, 8'd3};
        tbl[19] = '{4'h0, 4'hE,  1, 4'b0001, 1'b0, 4'h4, 8'd3};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < int'(tbl[i].cycles); c++) step(tbl[i].req, tbl[i].en, "table_step");
            check_const($sformatf("table_row%0d", i), tbl[i].stage, tbl[i].boot, tbl[i].cause, tbl[i].cnt);
        end

        // Long warm-reset request with a second source joining during HOLD
        repeat (32) step('0, '1, "to_working");
        check_const("working_before_hold", 4'b1111, 1'b1, 4'h4, 8'd3);
        for (int i = 0; i < 20; i++)
            step(4'b1000 | ((i >= 5 && i < 10) ? 4'b0100 : 4'b0000), '1, "long_hold");
        check_const("long_hold_cause", 4'b0000, 1'b0, 4'b1100, 8'd4);
        step('0, '1, "hold_exit");
        check_const("hold_exit_stage0", 4'b0001, 1'b0, 4'b1100, 8'd4);

        // Request during POR_WAIT restarts the delay without touching status
        do_reset();
        repeat (4) step('0, '1, "por_quiet");
        repeat (3) step(4'b0010, '1, "por_req");
        repeat (7) step('0, '1, "por_restart");
        check_const("por_restart_not_yet", 4'b0000, 1'b0, 4'h0, 8'd0);
        step('0, '1, "por_restart");
        check_const("por_restart_stage0", 4'b0001, 1'b0, 4'h0, 8'd0);

        // Counter saturation, then asynchronous reset mid-release
        for (int i = 0; i < 260; i++) begin
            step(4'b0001, '1, "sat_req");
            repeat (MINH) step('0, '1, "sat_hold");
        end
        check_const("cnt_saturated", 4'b0001, 1'b0, 4'h1, 8'd255);
        repeat (8) step('0, '1, "mid_release");
        check_const("mid_release", 4'b0011, 1'b0, 4'h1, 8'd255);
        do_reset();
        repeat (7) step('0, '1, "por_again");
        step('0, '1, "por_again");
        check_const("por_again_stage0", 4'b0001, 1'b0, 4'h0, 8'd0);

        // Randomized requests, enables and occasional resets against the model
        for (int i = 0; i < 3000; i++) begin
            logic [NREQ-1:0] r, e;
            r = ($urandom_range(0, 24) == 0) ? NREQ'($urandom) : '0;
            e = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '1;
            if ($urandom_range(0, 999) == 0) do_reset();
            step(r, e, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_fsm.md
Name: rst_seq_fsm

Overview:
Parametrised reset-release sequencer for the SCU reset generation unit. It releases NUM_STAGE reset domains in a fixed order after power-on, each stage separated by a programmable delay. It merges NUM_REQ maskable warm-reset request sources such as software, watchdogs and debug. It enforces a minimum reset-hold time and records the cause and count of warm resets for SCU status registers.

Parameters:
NUM_REQ, 4, number of warm-reset request sources (1..8)
NUM_STAGE, 4, number of sequentially released reset stages (1..8)
CNT_W, 8, width of the internal delay counter
POR_DELAY, 8, cycles in POR_WAIT with no request before stage 0 releases (1..2^CNT_W-1)
STAGE_DELAY, 8, cycles between consecutive stage releases, and from the last stage to boot_done (1..2^CNT_W-1)
MIN_HOLD, 4, minimum cycles all outputs stay low after a warm reset (1..2^CNT_W-1)

Ports:
clk_i  input  1  SCU kernel clock; the only clock
rst_n_i  input  1  por_rstn_sync; asynchronous assert, active-low
req_i  input  NUM_REQ  warm-reset requests, level, active-high, already synchronous to clk_i
req_en_i  input  NUM_REQ  per-source enable from SCU register; masked_req = req_i & req_en_i
stage_release_o  output  NUM_STAGE  registered, thermometer-coded reset release; bit k=1 means domain k is out of reset
boot_done_o  output  1  registered; 1 when all stages are released and the sequencer is in WORKING
rst_cause_o  output  NUM_REQ  sticky masked_req snapshot of the last warm reset
rst_cnt_o  output  8  warm-reset counter, saturating at 255

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk_i, rst_n_i).
- Reset values:
  - state = POR_WAIT, cnt = 0, stage index = 0.
  - All outputs are 0.
  - Only rst_n_i clears rst_cause_o and rst_cnt_o.
- Any masked_req bit counts as a request ("req"). req_en_i acts combinationally; there is no edge detection.
- All outputs are registered and update on the same edge as the state transition.
- POR_WAIT:
  - If req: cnt is cleared to 0.
  - Else if cnt == POR_DELAY-1: go to RELEASE, set stage_release_o[0]=1, clear cnt.
  - Else cnt increments.
  - Net effect: stage 0 rises on the POR_DELAY-th edge after the last req-high cycle (or after reset deassertion).
  - A request in POR_WAIT does not touch rst_cause_o or rst_cnt_o.
- RELEASE:
  - cnt counts 0..STAGE_DELAY-1.
  - When cnt hits STAGE_DELAY-1 with stages remaining: set the next stage bit and clear cnt.
  - When cnt hits STAGE_DELAY-1 after the last stage is set: go to WORKING and set boot_done_o=1.
  - Stage k is released k*STAGE_DELAY edges after stage 0. boot_done_o rises NUM_STAGE*STAGE_DELAY edges after stage 0.
- WORKING: hold outputs; no counting.
- Warm reset, when req occurs in RELEASE or WORKING:
  - Next edge: go to HOLD and clear stage_release_o and boot_done_o together, with no reverse sequencing.
  - On the same edge: rst_cause_o <= masked_req; rst_cnt_o increments, saturating at 255; cnt is cleared.
- HOLD:
  - Outputs stay 0.
  - cnt increments, saturating at MIN_HOLD-1.
  - Additional masked_req bits are ORed into rst_cause_o; rst_cnt_o does not change.
  - Exit when cnt == MIN_HOLD-1 and no req: go to RELEASE, set stage_release_o[0]=1, clear cnt. The POR_DELAY wait is skipped.
  - If req is still high, remain in HOLD indefinitely.
- Simultaneous events: a req in the same cycle as a stage or boot_done boundary wins; no new bit is set and HOLD is entered.
- Illegal state encodings recover to POR_WAIT with all outputs cleared.
- rst_n_i assertion mid-sequence returns the block to POR_WAIT immediately and clears all outputs and status.
- stage_release_o is always a thermometer code: bits are never set out of order and are never partially cleared.

Test Plan:
1. Defaults, no req after reset deassert → stage bits 0..3 rise at edges 8/16/24/32; boot_done_o rises at edge 40; rst_cnt_o=0.
2. req_i=4'b0010 (enabled) high for 3 cycles during POR_WAIT at edge 5 → count restarts; stage 0 rises 8 edges after req falls; rst_cause_o=0 and rst_cnt_o=0.
3. In WORKING, 1-cycle pulse req_i=4'b0001 → next edge all outputs 0, rst_cause_o=4'b0001, rst_cnt_o=1; stage 0 re-rises 4 edges after HOLD entry (MIN_HOLD); boot_done_o rises 32 edges after that.
4. In WORKING, req_i=4'b1000 held 20 cycles, with 4'b0100 added during HOLD → HOLD persists until req low; rst_cause_o=4'b1100, rst_cnt_o increments by 1 only.
5. req_en_i=4'b1110 with req_i=4'b0001 in WORKING → no effect; then req on bit 2 arriving on the same cycle stage 2 is due → stage 2 never sets, HOLD entered, rst_cause_o=4'b0100.
6. 260 warm resets → rst_cnt_o saturates at 255; then rst_n_i pulsed low mid-RELEASE → all outputs 0 asynchronously and the POR sequence restarts.
